dp_control_fsm: RTL and testbench
=================================

// Module: dp_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the 8-bit datapath: fetches an instruction byte via a req/ack handshake.
//  Holds it in an instruction register (IR), decodes it and drives the datapath control lines.
//  Control lines: alucontrol, WE, RE, ALU_ToMemReg, ALUMem_ToReg, dmem_we. Owns the program counter.
//  Sits between instruction memory and the datapath; one instruction in flight at a time.
// PARAMETERS
//  RESET_PC   8'h00  PC value loaded on reset.
//  HALT_OP    3'b111 Opcode (IR[4:2]) that stops sequencing.
// PORTS
//  clk            in   1  Single clock; all state updates on rising edge.
//  reset          in   1  Synchronous, active-high reset.
//  start          in   1  Level; leaves IDLE when high.
//  imem_ack       in   1  Instruction memory has valid data on imem_data this cycle.
//  imem_data      in   8  Instruction byte.
//  imem_req       out  1  Fetch request for address pc.
//  pc             out  8  Program counter (signed view on datapath side; arithmetic is mod 256).
//  instr          out  8  IR contents: [7:6] immediate, [5] reg select, [4:2] opcode, [1:0] reserved.
//  alucontrol     out  3  ALU op, equals IR[4:2] for ALU/STORE ops, 3'b000 otherwise.
//  WE             out  2  One-hot register write enable (bit = IR[5]).
//  RE             out  2  One-hot register read enable (bit = IR[5]).
//  ALU_ToMemReg   out  1  1 = ALU result routed to dmem, 0 = to register file.
//  ALUMem_ToReg   out  1  1 = dmem data selected for register write, 0 = ALU path.
//  dmem_we        out  1  Data memory write strobe, single cycle.
//  busy           out  1  High in every state except IDLE and HALT.
//  halted         out  1  High in HALT.
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, instr=8'h00, all other outputs 0. Reset wins over every event, any state.
//  Opcodes IR[4:2]: 000 ADD,001 SUB,010 AND,011 OR,100 XOR (ALU->reg); 101 LOAD (dmem->reg);
//    110 STORE (ALU->dmem); 111 HALT. IR[1:0] ignored.
//  States and transitions:
//   IDLE  : start=1 -> FETCH.
//   FETCH : imem_req=1; stay until imem_ack=1, then IR<=imem_data -> DECODE. req stays high while waiting.
//   DECODE: opcode==HALT_OP -> HALT (pc not advanced); else RE=onehot(IR[5]) -> EXEC.
//   EXEC  : RE held; alucontrol driven; STORE: ALU_ToMemReg=1, dmem_we=1 for this cycle only -> WB.
//   WB    : ALU ops: WE=onehot(IR[5]), ALUMem_ToReg=0; LOAD: WE=onehot(IR[5]), ALUMem_ToReg=1;
//           STORE: WE=0. pc<=pc+1 (8'hFF wraps to 8'h00) -> FETCH.
//   HALT  : terminal; only reset exits. start ignored.
//  All control outputs registered (Moore); asserted exactly in the stated state, 0 elsewhere.
//  WE and dmem_we never both high; WE high only in WB; at most one WE bit high.
//  Latency per non-HALT instruction: 3 cycles + fetch wait (ack in first FETCH cycle -> 4 cycles FETCH..WB).
//  imem_ack outside FETCH ignored; imem_data only sampled in FETCH with ack.
//  start deasserted after leaving IDLE has no effect; sequencing continues until HALT.
//  reset mid-instruction: partial instruction discarded, no WE/dmem_we pulse in the following cycle.
// TESTING
//  Reset then start=1, imem_ack=1 every cycle, instr 8'b01_0_000_00 -> RE=01 in DECODE/EXEC, WE=01 in WB, pc 0->1.
//  Fetch stall: ack held low 5 cycles -> imem_req high 6 cycles, no control pulses, IR unchanged until ack.
//  LOAD 8'b00_1_101_00 -> WB: WE=10, ALUMem_ToReg=1; STORE 8'b11_0_110_00 -> EXEC: dmem_we=1 one cycle, WE=0.
//  pc=8'hFF with ADD -> after WB pc=8'h00, fetch continues at 0.
//  HALT 8'b00_0_111_00 at pc=3 -> halted=1, busy=0, pc stays 3, start pulse ignored; reset -> IDLE, pc=RESET_PC.
//  Assert reset in EXEC of STORE -> dmem_we=0 next cycle, state IDLE, all outputs 0.

Source files
------------

// File: rtl/dp_control_fsm.sv
// dp_control_fsm: multi-cycle fetch/decode/execute/writeback sequencer for the
// 8-bit datapath. It fetches one instruction byte through a req/ack handshake,
// holds it in the instruction register and drives the datapath control lines
// from registered (Moore) outputs. It also owns the program counter.
module dp_control_fsm #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [2:0] HALT_OP  = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       imem_req,
  output logic [7:0] pc,
  output logic [7:0] instr,
  output logic [2:0] alucontrol,
  output logic [1:0] WE,
  output logic [1:0] RE,
  output logic       ALU_ToMemReg,
  output logic       ALUMem_ToReg,
  output logic       dmem_we,
  output logic       busy,
  output logic       halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;

  logic       req_q, req_d;
  logic [2:0] alu_q, alu_d;
  logic [1:0] we_q, we_d;
  logic [1:0] re_q, re_d;
  logic       atm_q, atm_d;
  logic       amr_q, amr_d;
  logic       dwe_q, dwe_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;

  // Decoded view of the instruction that will be held next cycle
  logic [2:0] op_d;
  logic [1:0] sel_onehot_d;
  logic       is_halt_d, is_load_d, is_store_d, is_alu_d;

  // Next-state logic: sequencing, instruction capture and PC advance
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // Data is only trusted in FETCH, and only when acknowledged
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // HALT leaves the PC pointing at the halt instruction
        if (ir_q[4:2] == HALT_OP) state_d = S_HALT;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Instruction field decode on the next-cycle IR contents
  always_comb begin
    op_d         = ir_d[4:2];
    sel_onehot_d = ir_d[5] ? 2'b10 : 2'b01;
    is_halt_d    = (op_d == HALT_OP);
    is_load_d    = (op_d == OP_LOAD) && !is_halt_d;
    is_store_d   = (op_d == OP_STORE) && !is_halt_d;
    is_alu_d     = (op_d <= OP_XOR) && !is_halt_d;
  end

  // Control outputs for the state being entered, so each registered line is
  // high exactly while the FSM sits in the state that owns it
  always_comb begin
    req_d    = (state_d == S_FETCH);
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_EXEC)  || (state_d == S_WB);
    halted_d = (state_d == S_HALT);

    re_d = 2'b00;
    if (((state_d == S_DECODE) && !is_halt_d) || (state_d == S_EXEC))
      re_d = sel_onehot_d;

    alu_d = 3'b000;
    if ((state_d == S_EXEC) && (is_alu_d || is_store_d))
      alu_d = op_d;

    // Store is the only memory write; it lasts for the single EXEC cycle
    atm_d = (state_d == S_EXEC) && is_store_d;
    dwe_d = (state_d == S_EXEC) && is_store_d;

    // Register writeback never coincides with a memory write
    we_d = 2'b00;
    if ((state_d == S_WB) && (is_alu_d || is_load_d))
      we_d = sel_onehot_d;
    amr_d = (state_d == S_WB) && is_load_d;
  end

  // State, IR, PC and output registers; reset discards any partial instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 8'h00;
      req_q    <= 1'b0;
      alu_q    <= 3'b000;
      we_q     <= 2'b00;
      re_q     <= 2'b00;
      atm_q    <= 1'b0;
      amr_q    <= 1'b0;
      dwe_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      alu_q    <= alu_d;
      we_q     <= we_d;
      re_q     <= re_d;
      atm_q    <= atm_d;
      amr_q    <= amr_d;
      dwe_q    <= dwe_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req     = req_q;
  assign pc           = pc_q;
  assign instr        = ir_q;
  assign alucontrol   = alu_q;
  assign WE           = we_q;
  assign RE           = re_q;
  assign ALU_ToMemReg = atm_q;
  assign ALUMem_ToReg = amr_q;
  assign dmem_we      = dwe_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_dp_control_fsm.sv
// Testbench for dp_control_fsm: directed and random instructions checked
// cycle by cycle against an instruction-level reference model.
module tb_dp_control_fsm;

  logic       clk;
  logic       reset;
  logic       start;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       imem_req;
  logic [7:0] pc;
  logic [7:0] instr;
  logic [2:0] alucontrol;
  logic [1:0] WE;
  logic [1:0] RE;
  logic       ALU_ToMemReg;
  logic       ALUMem_ToReg;
  logic       dmem_we;
  logic       busy;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC and IR
  int         m_pc;
  logic [7:0] m_ir;

  dp_control_fsm #(.RESET_PC(8'h00), .HALT_OP(3'b111)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .imem_req(imem_req), .pc(pc), .instr(instr),
    .alucontrol(alucontrol), .WE(WE), .RE(RE),
    .ALU_ToMemReg(ALU_ToMemReg), .ALUMem_ToReg(ALUMem_ToReg),
    .dmem_we(dmem_we), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against expectations plus the model PC/IR
  task automatic check_outs(input string tag, input logic req, input logic [2:0] alu,
                            input logic [1:0] we, input logic [1:0] re, input logic atm,
                            input logic amr, input logic dwe, input logic bsy, input logic hlt);
    chk({tag, ".req"},    {7'd0, imem_req},     {7'd0, req});
    chk({tag, ".pc"},     pc,                   m_pc[7:0]);
    chk({tag, ".instr"},  instr,                m_ir);
    chk({tag, ".alu"},    {5'd0, alucontrol},   {5'd0, alu});
    chk({tag, ".WE"},     {6'd0, WE},           {6'd0, we});
    chk({tag, ".RE"},     {6'd0, RE},           {6'd0, re});
    chk({tag, ".atm"},    {7'd0, ALU_ToMemReg}, {7'd0, atm});
    chk({tag, ".amr"},    {7'd0, ALUMem_ToReg}, {7'd0, amr});
    chk({tag, ".dwe"},    {7'd0, dmem_we},      {7'd0, dwe});
    chk({tag, ".busy"},   {7'd0, busy},         {7'd0, bsy});
    chk({tag, ".halted"}, {7'd0, halted},       {7'd0, hlt});
  endtask

  function automatic logic [1:0] onehot(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction

  // Noise on inputs the FSM must ignore outside FETCH
  task automatic noise();
    imem_ack  = 1'($urandom);
    imem_data = 8'($urandom);
    start     = 1'($urandom);
  endtask

  // Run one instruction from the first FETCH cycle; for HALT stops after DECODE
  task automatic do_instr(input logic [7:0] ins, input int stall);
    logic [2:0] op;
    logic [1:0] oh;
    logic       ld, st;
    op = ins[4:2];
    oh = onehot(ins[5]);
    ld = (op == 3'b101);
    st = (op == 3'b110);
    for (int k = 0; k < stall; k++) begin
      check_outs("fetch_wait", 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      imem_ack  = 1'b0;
      imem_data = 8'($urandom);
      start     = 1'($urandom);
      step();
    end
    check_outs("fetch", 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    imem_ack  = 1'b1;
    imem_data = ins;
    step();
    m_ir = ins;
    noise();
    if (op == 3'b111) begin
      check_outs("decode_halt", 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      $display("instr pc=%0h ir=%0h HALT stall=%0d", m_pc, ins, stall);
      return;
    end
    check_outs("decode", 1'b0, 3'd0, 2'd0, oh, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    noise();
    step();
    check_outs("exec", 1'b0, ld ? 3'd0 : op, 2'd0, oh, st, 1'b0, st, 1'b1, 1'b0);
    noise();
    step();
    check_outs("wb", 1'b0, 3'd0, st ? 2'd0 : oh, 2'd0, 1'b0, ld, 1'b0, 1'b1, 1'b0);
    noise();
    step();
    $display("instr pc=%0h ir=%0h op=%0d stall=%0d", m_pc, ins, op, stall);
    m_pc = (m_pc + 1) % 256;
  endtask

  function automatic logic [7:0] rand_instr();
    logic [7:0] r;
    r      = 8'($urandom);
    r[4:2] = 3'($urandom_range(0, 6));
    return r;
  endfunction

  initial begin
    m_pc      = 0;
    m_ir      = 8'h00;
    reset     = 1'b1;
    start     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 8'hA5;
    step();
    step();
    check_outs("reset", 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // IDLE holds without start; ack/data ignored
    reset = 1'b0;
    start = 1'b0;
    step();
    check_outs("idle", 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();

    // ADD r0, then fetch stall with LOAD r1, then STORE
    do_instr(8'b01_0_000_00, 0);
    do_instr(8'b00_1_101_00, 5);
    do_instr(8'b11_0_110_00, 0);

    for (int i = 0; i < 20; i++) do_instr(rand_instr(), $urandom_range(0, 3));

    // Walk up to pc=FF, then an ADD must wrap the PC to 00
    while (m_pc != 255) do_instr(rand_instr(), $urandom_range(0, 1));
    do_instr(8'b00_0_000_00, 0);
    chk("pc_wrap", pc, 8'h00);

    // Reach pc=3 and halt there
    while (m_pc != 3) do_instr(rand_instr(), 0);
    do_instr(8'b00_0_111_00, 1);
    for (int k = 0; k < 4; k++) begin
      check_outs("halt", 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      start    = (k == 1);
      imem_ack = 1'b1;
      step();
    end
    chk("halt_pc", pc, 8'h03);

    // Reset from HALT returns to IDLE at RESET_PC
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    m_pc  = 0;
    m_ir  = 8'h00;
    check_outs("halt_reset", 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();

    // STORE interrupted by reset in EXEC
    check_outs("st_fetch", 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    imem_ack  = 1'b1;
    imem_data = 8'b11_0_110_00;
    step();
    m_ir = 8'b11_0_110_00;
    check_outs("st_decode", 1'b0, 3'd0, 2'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("st_exec", 1'b0, 3'b110, 2'd0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    m_ir = 8'h00;
    check_outs("exec_reset", 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    step();
    check_outs("post_reset_idle", 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    check_outs("restart_fetch", 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
